// File: rtl/matmul_pkg.sv
// Shared types and default widths for the matrix-multiply address generator.
package matmul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mag_state_t;

   localparam int ADDR_W_DEF = 16;
   localparam int DIM_W_DEF  = 8;

endpackage

// File: rtl/matmul_addr_gen_loop_counter.sv
// One loop index: counts on enable, wraps to 0 after limit-1 and flags the wrap.
module loop_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] limit,
   output logic [W-1:0] idx,
   output logic         wrap
);

   assign wrap = en && (idx == limit - W'(1));

   always_ff @(posedge clk) begin
      if (rst || clr)
         idx <= '0;
      else if (wrap)
         idx <= '0;
      else if (en)
         idx <= idx + W'(1);
   end

endmodule

// File: rtl/matmul_addr_gen.sv
// Walks i/j/k over an n x n matmul and emits A/B/C addresses per beat using
// running pointers instead of multipliers.
//
// state | meaning
// IDLE  | waiting for start; start with n==0 goes straight to DONE
// RUN   | presenting tuples, one beat per valid && ready
// DONE  | one-cycle done pulse, then back to IDLE
module matmul_addr_gen
   import matmul_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DIM_W  = DIM_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DIM_W-1:0]  n,
   input  logic [ADDR_W-1:0] a_base,
   input  logic [ADDR_W-1:0] b_base,
   input  logic [ADDR_W-1:0] c_base,
   input  logic              ready,
   output logic              valid,
   output logic [ADDR_W-1:0] a_addr,
   output logic [ADDR_W-1:0] b_addr,
   output logic [ADDR_W-1:0] c_addr,
   output logic              first_k,
   output logic              last_k,
   output logic              busy,
   output logic              done
);

   mag_state_t state, state_nxt;

   logic [DIM_W-1:0]  n_q;
   logic [ADDR_W-1:0] b_base_q;
   logic [ADDR_W-1:0] a_row, b_ptr, c_ptr;
   logic [DIM_W-1:0]  k_idx, j_idx, i_idx;
   logic [DIM_W-1:0]  j_next;
   logic              k_wrap, j_wrap, i_wrap;
   logic              accept, beat;
   logic [ADDR_W-1:0] n_ext;

   assign accept = (state == IDLE) && start;
   assign beat   = (state == RUN) && ready;
   assign n_ext  = ADDR_W'(n_q);
   assign j_next = j_wrap ? '0 : j_idx + DIM_W'(1);

   loop_counter #(.W(DIM_W)) u_k (
      .clk(clk), .rst(rst), .clr(accept), .en(beat),
      .limit(n_q), .idx(k_idx), .wrap(k_wrap)
   );

   loop_counter #(.W(DIM_W)) u_j (
      .clk(clk), .rst(rst), .clr(accept), .en(k_wrap),
      .limit(n_q), .idx(j_idx), .wrap(j_wrap)
   );

   loop_counter #(.W(DIM_W)) u_i (
      .clk(clk), .rst(rst), .clr(accept), .en(j_wrap),
      .limit(n_q), .idx(i_idx), .wrap(i_wrap)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (n != '0) ? RUN : DONE;
         RUN:     if (beat && i_wrap) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         n_q      <= '0;
         b_base_q <= '0;
         a_row    <= '0;
         b_ptr    <= '0;
         c_ptr    <= '0;
      end else if (accept) begin
         n_q      <= n;
         b_base_q <= b_base;
         a_row    <= a_base;
         b_ptr    <= b_base;
         c_ptr    <= c_base;
      end else if (beat) begin
         // k wrap restarts B at the top of the next column and steps C by one
         if (k_wrap) begin
            b_ptr <= b_base_q + ADDR_W'(j_next);
            c_ptr <= c_ptr + ADDR_W'(1);
         end else begin
            b_ptr <= b_ptr + n_ext;
         end
         if (j_wrap)
            a_row <= a_row + n_ext;
      end
   end

   assign valid   = (state == RUN);
   assign busy    = (state == RUN);
   assign done    = (state == DONE);
   assign a_addr  = a_row + ADDR_W'(k_idx);
   assign b_addr  = b_ptr;
   assign c_addr  = c_ptr;
   assign first_k = valid && (k_idx == '0);
   assign last_k  = valid && (k_idx == n_q - DIM_W'(1));

   logic unused_i;
   assign unused_i = |i_idx;

endmodule

// File: tb/tb_matmul_addr_gen.sv
// Directed bench for matmul_addr_gen: hand-computed tuples, checked at negedge.
module tb_matmul_addr_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  n;
   logic [15:0] a_base, b_base, c_base;
   logic        ready;
   logic        valid, first_k, last_k, busy, done;
   logic [15:0] a_addr, b_addr, c_addr;

   int errors = 0;
   int checks = 0;

   logic [15:0] ea [8];
   logic [15:0] eb [8];
   logic [15:0] ec [8];
   logic [3:0]  rpat;

   always #5 clk = ~clk;

   matmul_addr_gen dut (
      .clk(clk), .rst(rst), .start(start), .n(n),
      .a_base(a_base), .b_base(b_base), .c_base(c_base),
      .ready(ready), .valid(valid),
      .a_addr(a_addr), .b_addr(b_addr), .c_addr(c_addr),
      .first_k(first_k), .last_k(last_k), .busy(busy), .done(done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic launch(input logic [7:0] nn, input logic [15:0] ab, bb, cb);
      n = nn; a_base = ab; b_base = bb; c_base = cb;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      int beats;
      int cyc;
      ea = '{16'd0, 16'd1, 16'd0, 16'd1, 16'd2, 16'd3, 16'd2, 16'd3};
      eb = '{16'd16, 16'd18, 16'd17, 16'd19, 16'd16, 16'd18, 16'd17, 16'd19};
      ec = '{16'd32, 16'd32, 16'd33, 16'd33, 16'd34, 16'd34, 16'd35, 16'd35};
      rpat = 4'b1001;
      rst = 1'b1; start = 1'b0; n = '0; a_base = '0; b_base = '0; c_base = '0; ready = 1'b1;
      repeat (2) @(negedge clk);

      chk("rst_valid", valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_first", first_k, 0);
      chk("rst_last", last_k, 0);
      chk("rst_addr", {a_addr, b_addr | c_addr}, 0);
      rst = 1'b0;

      // basic 2x2
      launch(8'd2, 16'd0, 16'd16, 16'd32);
      for (int b = 0; b < 8; b++) begin
         chk($sformatf("basic_valid%0d", b), valid, 1);
         chk($sformatf("basic_a%0d", b), a_addr, ea[b]);
         chk($sformatf("basic_b%0d", b), b_addr, eb[b]);
         chk($sformatf("basic_c%0d", b), c_addr, ec[b]);
         chk($sformatf("basic_first%0d", b), first_k, (b % 2) == 0);
         chk($sformatf("basic_last%0d", b), last_k, (b % 2) == 1);
         @(negedge clk);
      end
      chk("basic_done", done, 1);
      chk("basic_valid_end", valid, 0);
      @(negedge clk);
      chk("basic_done_pulse", done, 0);

      // zero dimension
      launch(8'd0, 16'd5, 16'd6, 16'd7);
      chk("zero_valid", valid, 0);
      chk("zero_done", done, 1);
      @(negedge clk);
      chk("zero_done_pulse", done, 0);
      chk("zero_valid2", valid, 0);

      // single element
      launch(8'd1, 16'd5, 16'd7, 16'd9);
      chk("one_valid", valid, 1);
      chk("one_addr", {8'd0, a_addr[7:0], b_addr[7:0], c_addr[7:0]}, 32'h00050709);
      chk("one_first", first_k, 1);
      chk("one_last", last_k, 1);
      @(negedge clk);
      chk("one_done", done, 1);
      chk("one_valid_end", valid, 0);
      @(negedge clk);

      // backpressure, ready pattern 1,0,0,1
      launch(8'd2, 16'd0, 16'd16, 16'd32);
      beats = 0;
      cyc = 0;
      while (beats < 8 && cyc < 100) begin
         ready = rpat[cyc % 4];
         chk($sformatf("bp_valid%0d", cyc), valid, 1);
         chk($sformatf("bp_a%0d", cyc), a_addr, ea[beats]);
         chk($sformatf("bp_b%0d", cyc), b_addr, eb[beats]);
         chk($sformatf("bp_c%0d", cyc), c_addr, ec[beats]);
         if (valid && ready) beats++;
         cyc++;
         @(negedge clk);
      end
      chk("bp_beats", beats, 8);
      chk("bp_done", done, 1);
      ready = 1'b1;
      @(negedge clk);

      // reset mid-job at beat 3 of n=3
      launch(8'd3, 16'd100, 16'd200, 16'd300);
      repeat (3) @(negedge clk);
      chk("rst3_busy_before", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst3_valid", valid, 0);
      chk("rst3_busy", busy, 0);
      chk("rst3_done", done, 0);
      chk("rst3_flags", {first_k, last_k}, 0);
      chk("rst3_a", a_addr, 0);
      chk("rst3_b", b_addr, 0);
      chk("rst3_c", c_addr, 0);
      beats = 0;
      for (int c = 0; c < 4; c++) begin
         if (done) beats++;
         @(negedge clk);
      end
      chk("rst3_no_done", beats, 0);

      // rst wins over start
      rst = 1'b1;
      n = 8'd2; start = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      chk("rst_start_valid", valid, 0);
      @(negedge clk);
      chk("rst_start_valid2", valid, 0);

      // start during RUN ignored; n=3 must still take 27 beats
      launch(8'd3, 16'd0, 16'd0, 16'd0);
      beats = 0;
      cyc = 0;
      while (!done && cyc < 100) begin
         start = (cyc == 5);
         n = (cyc == 5) ? 8'd1 : 8'd3;
         if (valid && ready) beats++;
         cyc++;
         @(negedge clk);
      end
      start = 1'b0;
      chk("busy_start_done", done, 1);
      chk("busy_start_beats", beats, 27);
      @(negedge clk);

      // address wrap
      launch(8'd2, 16'hFFFF, 16'd0, 16'd0);
      chk("wrap_a0", a_addr, 16'hFFFF);
      @(negedge clk);
      chk("wrap_a1", a_addr, 16'h0000);
      repeat (7) @(negedge clk);
      chk("wrap_done", done, 1);
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
